// File: rtl/pe_psum_acc_pkg.sv
// Shared widths and types for the PE partial-sum accumulator and its fold datapath.
package pe_psum_acc_pkg;

    localparam int unsigned AU_OD_WD   = 12;
    localparam int unsigned PSUM_WD    = 16;
    localparam int unsigned ACC_CNT_WD = 8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_st_e;

    typedef logic signed [PSUM_WD-1:0] psum_t;

endpackage

// File: rtl/psum_sat_fold.sv
// Combinational saturating fold: sat(sat(acc <<< shamt) + sext(in_sum)).
module psum_sat_fold #(
    parameter int unsigned IWd    = 12,
    parameter int unsigned PsumWd = 16
) (
    input  logic signed [PsumWd-1:0] acc,
    input  logic        [1:0]        shamt,
    input  logic signed [IWd-1:0]    in_sum,
    output logic signed [PsumWd-1:0] res
);

    // Headroom for a 3-bit left shift plus one carry from the add.
    localparam int unsigned W = ((PsumWd > IWd) ? PsumWd : IWd) + 4;

    function automatic logic signed [PsumWd-1:0] sat(input logic signed [W-1:0] v);
        if (v[W-1:PsumWd-1] == {(W-PsumWd+1){v[W-1]}})
            return v[PsumWd-1:0];
        else if (v[W-1])
            return {1'b1, {(PsumWd-1){1'b0}}};
        else
            return {1'b0, {(PsumWd-1){1'b1}}};
    endfunction

    logic signed [W-1:0] acc_w;
    logic signed [W-1:0] shl_w;
    logic signed [W-1:0] base_w;
    logic signed [W-1:0] sum_w;

    always_comb begin
        acc_w  = W'(acc);
        shl_w  = acc_w <<< shamt;
        base_w = W'(sat(shl_w));
        sum_w  = W'(in_sum);
        res    = sat(base_w + sum_w);
    end

endmodule

// File: rtl/pe_psum_acc.sv
// Partial-sum accumulator: folds (accnum+1) unit sums per psum and hands the result out on rdy/ack/zero.
module pe_psum_acc
    import pe_psum_acc_pkg::*;
#(
    parameter int unsigned IWd    = AU_OD_WD,
    parameter int unsigned PsumWd = PSUM_WD,
    parameter int unsigned CntWd  = ACC_CNT_WD
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_cont_reset,
    input  logic                     i_cont_stall,
    input  logic        [CntWd-1:0]  i_cont_accnum,
    input  logic        [1:0]        i_cont_shamt,
    input  logic signed [IWd-1:0]    i_sum,
    input  logic                     sum_rdy,
    input  logic                     sum_zero,
    output logic                     sum_ack,
    output logic signed [PsumWd-1:0] o_psum,
    output logic                     psum_rdy,
    output logic                     psum_zero,
    input  logic                     psum_ack
);

    acc_st_e                  state;
    logic [CntWd-1:0]         cnt;
    logic [CntWd-1:0]         accnum_l;
    logic [CntWd-1:0]         accnum_eff;
    logic [1:0]               shamt_l;
    logic [1:0]               shamt_eff;
    logic signed [PsumWd-1:0] acc;
    logic signed [PsumWd-1:0] acc_base;
    logic signed [PsumWd-1:0] acc_next;
    logic                     zacc;
    logic                     zero_next;
    logic                     first;
    logic                     last;

    // The first sum of a psum uses the live config so the latch costs no cycle.
    always_comb begin
        first      = (cnt == '0);
        accnum_eff = first ? i_cont_accnum : accnum_l;
        shamt_eff  = first ? i_cont_shamt : shamt_l;
        acc_base   = first ? '0 : acc;
        zero_next  = (first | zacc) & sum_zero;
        last       = (cnt == accnum_eff);
    end

    assign sum_ack = i_cont_stall & sum_rdy & ((state == ACC) | psum_ack);

    psum_sat_fold #(
        .IWd    (IWd),
        .PsumWd (PsumWd)
    ) u_fold (
        .acc    (acc_base),
        .shamt  (shamt_eff),
        .in_sum (i_sum),
        .res    (acc_next)
    );

    // NOTE: sequential state uses non-blocking assignments only; a later
    // assignment in the same block overrides an earlier one, which is how a
    // same-cycle last sum keeps psum_rdy high over the ack release below.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ACC;
            cnt       <= '0;
            accnum_l  <= '0;
            shamt_l   <= '0;
            acc       <= '0;
            zacc      <= 1'b1;
            o_psum    <= '0;
            psum_rdy  <= 1'b0;
            psum_zero <= 1'b1;
        end else if (i_cont_reset) begin
            state     <= ACC;
            cnt       <= '0;
            accnum_l  <= '0;
            shamt_l   <= '0;
            acc       <= '0;
            zacc      <= 1'b1;
            o_psum    <= '0;
            psum_rdy  <= 1'b0;
            psum_zero <= 1'b1;
        end else if (i_cont_stall) begin
            if ((state == OUT) && psum_ack) begin
                psum_rdy <= 1'b0;
                state    <= ACC;
            end
            if (sum_ack) begin
                if (first) begin
                    accnum_l <= i_cont_accnum;
                    shamt_l  <= i_cont_shamt;
                end
                if (last) begin
                    o_psum    <= acc_next;
                    psum_zero <= zero_next;
                    psum_rdy  <= 1'b1;
                    cnt       <= '0;
                    state     <= OUT;
                end else begin
                    cnt  <= cnt + CntWd'(1);
                    acc  <= acc_next;
                    zacc <= zero_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_psum_acc.sv
// Randomised and directed bench for pe_psum_acc against an arithmetic psum model.
module tb_pe_psum_acc;
    import pe_psum_acc_pkg::*;

    localparam int unsigned IWd    = AU_OD_WD;
    localparam int unsigned PsumWd = PSUM_WD;
    localparam int unsigned CntWd  = ACC_CNT_WD;

    logic                 i_clk;
    logic                 i_rstn;
    logic                 i_cont_reset;
    logic                 i_cont_stall;
    logic [CntWd-1:0]     i_cont_accnum;
    logic [1:0]           i_cont_shamt;
    logic signed [IWd-1:0] i_sum;
    logic                 sum_rdy;
    logic                 sum_zero;
    logic                 sum_ack;
    psum_t                o_psum;
    logic                 psum_rdy;
    logic                 psum_zero;
    logic                 psum_ack;

    int checks = 0;
    int errors = 0;
    int vals[$];
    bit zs[$];

    pe_psum_acc dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_cont_reset  (i_cont_reset),
        .i_cont_stall  (i_cont_stall),
        .i_cont_accnum (i_cont_accnum),
        .i_cont_shamt  (i_cont_shamt),
        .i_sum         (i_sum),
        .sum_rdy       (sum_rdy),
        .sum_zero      (sum_zero),
        .sum_ack       (sum_ack),
        .o_psum        (o_psum),
        .psum_rdy      (psum_rdy),
        .psum_zero     (psum_zero),
        .psum_ack      (psum_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int clamp(input int v);
        int mx;
        int mn;
        mx = (1 <<< (PsumWd - 1)) - 1;
        mn = -(1 <<< (PsumWd - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // MSB-first composition: each step multiplies the running value by 2^shamt.
    function automatic int model_psum(input int shamt);
        int a;
        a = 0;
        foreach (vals[i]) a = clamp(clamp(a * (1 << shamt)) + vals[i]);
        return a;
    endfunction

    function automatic bit model_zero();
        bit z;
        z = 1'b1;
        foreach (zs[i]) z = z & zs[i];
        return z;
    endfunction

    task automatic check_out(input string tag, input bit exp_rdy, input int exp_v, input bit exp_z);
        checks++;
        if (psum_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL %s psum_rdy got %0b exp %0b", tag, psum_rdy, exp_rdy);
        end
        checks++;
        if (o_psum !== PsumWd'(exp_v)) begin
            errors++;
            $display("FAIL %s o_psum got %0d exp %0d", tag, o_psum, exp_v);
        end
        checks++;
        if (psum_zero !== exp_z) begin
            errors++;
            $display("FAIL %s psum_zero got %0b exp %0b", tag, psum_zero, exp_z);
        end
    endtask

    task automatic expect_ack(input string tag, input bit exp_ack);
        checks++;
        if (sum_ack !== exp_ack) begin
            errors++;
            $display("FAIL %s sum_ack got %0b exp %0b", tag, sum_ack, exp_ack);
        end
    endtask

    task automatic expect_rdy(input string tag, input bit exp_rdy);
        checks++;
        if (psum_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL %s psum_rdy got %0b exp %0b", tag, psum_rdy, exp_rdy);
        end
    endtask

    // Streams vals/zs back-to-back with psum_ack held high; config is scrambled after
    // the first sum so any failure to latch it shows up as a wrong count or shift.
    task automatic run_psum(input int shamt, input string tag);
        int exp_v;
        bit exp_z;
        int n;
        exp_v = model_psum(shamt);
        exp_z = model_zero();
        n = vals.size();
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (i == 0) begin
                i_cont_accnum = CntWd'(n - 1);
                i_cont_shamt  = 2'(shamt);
            end else begin
                i_cont_accnum = CntWd'($urandom);
                i_cont_shamt  = 2'($urandom);
            end
            psum_ack = 1'b1;
            sum_rdy  = 1'b1;
            i_sum    = IWd'(vals[i]);
            sum_zero = zs[i];
            #1;
            expect_ack(tag, 1'b1);
            @(posedge i_clk);
            #1;
            if (i < n - 1) expect_rdy(tag, 1'b0);
            else check_out(tag, 1'b1, exp_v, exp_z);
        end
        @(negedge i_clk);
        sum_rdy = 1'b0;
    endtask

    task automatic set_vals(input int a, input int b, input int c, input int d);
        vals = '{a, b, c, d};
        zs   = '{a == 0, b == 0, c == 0, d == 0};
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_cont_reset = 1'b0; i_cont_stall = 1'b1;
        i_cont_accnum = '0; i_cont_shamt = '0; i_sum = '0;
        sum_rdy = 1'b0; sum_zero = 1'b0; psum_ack = 1'b0;
        #12;
        check_out("reset", 1'b0, 0, 1'b1);
        expect_ack("reset", 1'b0);
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic test_plain_acc();
        set_vals(5, -2, 7, 1);
        run_psum(0, "plain");
        checks++;
        if (o_psum !== 16'sd11) begin
            errors++;
            $display("FAIL plain_const o_psum got %0d exp 11", o_psum);
        end
    endtask

    task automatic test_bitplane();
        set_vals(1, 0, 1, 1);
        run_psum(1, "bitplane_pos");
        set_vals(-1, 0, 0, 1);
        run_psum(1, "bitplane_neg");
        checks++;
        if (o_psum !== -16'sd7) begin
            errors++;
            $display("FAIL bitplane_const o_psum got %0d exp -7", o_psum);
        end
    endtask

    task automatic test_saturation();
        vals.delete(); zs.delete();
        for (int i = 0; i < 256; i++) begin vals.push_back(200); zs.push_back(1'b0); end
        run_psum(0, "sat_pos");
        vals.delete(); zs.delete();
        for (int i = 0; i < 256; i++) begin vals.push_back(-200); zs.push_back(1'b0); end
        run_psum(0, "sat_neg");
    endtask

    task automatic test_backpressure();
        @(negedge i_clk);
        i_cont_accnum = 8'd1; i_cont_shamt = 2'd0; psum_ack = 1'b0;
        sum_rdy = 1'b1; sum_zero = 1'b0; i_sum = 12'sd3;
        #1 expect_ack("bp_fill0", 1'b1);
        @(negedge i_clk);
        i_sum = 12'sd4;
        #1 expect_ack("bp_fill1", 1'b1);
        @(posedge i_clk);
        #1 check_out("bp_first", 1'b1, 7, 1'b0);
        @(negedge i_clk);
        i_sum = 12'sd10;
        for (int i = 0; i < 5; i++) begin
            #1 expect_ack("bp_hold", 1'b0);
            @(posedge i_clk);
            #1 check_out("bp_hold", 1'b1, 7, 1'b0);
            @(negedge i_clk);
        end
        psum_ack = 1'b1;
        #1 expect_ack("bp_release", 1'b1);
        @(posedge i_clk);
        #1 expect_rdy("bp_release", 1'b0);
        @(negedge i_clk);
        psum_ack = 1'b0; i_sum = -12'sd20;
        #1 expect_ack("bp_second", 1'b1);
        @(posedge i_clk);
        #1 check_out("bp_nobubble", 1'b1, -10, 1'b0);
        // accnum=0 with same-cycle ack: every accepted sum reloads the held psum.
        @(negedge i_clk);
        i_cont_accnum = 8'd0; psum_ack = 1'b1; i_sum = 12'sd55;
        #1 expect_ack("bp_reload0", 1'b1);
        @(posedge i_clk);
        #1 check_out("bp_reload0", 1'b1, 55, 1'b0);
        @(negedge i_clk);
        i_sum = -12'sd1;
        @(posedge i_clk);
        #1 check_out("bp_reload1", 1'b1, -1, 1'b0);
        @(negedge i_clk);
        sum_rdy = 1'b0;
        @(posedge i_clk);
        #1 expect_rdy("bp_drain", 1'b0);
    endtask

    task automatic test_zero_flag();
        vals = '{0, 0, 0}; zs = '{1, 1, 1};
        run_psum(0, "zero_all");
        vals = '{0, 9, 0}; zs = '{1, 0, 1};
        run_psum(0, "zero_one");
    endtask

    task automatic test_disruptions();
        // Sync reset after two of four sums, with stall low to show reset still wins.
        @(negedge i_clk);
        i_cont_accnum = 8'd3; i_cont_shamt = 2'd0; psum_ack = 1'b1;
        sum_rdy = 1'b1; sum_zero = 1'b0; i_sum = 12'sd100;
        @(negedge i_clk);
        i_sum = 12'sd200;
        @(negedge i_clk);
        sum_rdy = 1'b0; i_cont_reset = 1'b1; i_cont_stall = 1'b0;
        @(posedge i_clk);
        #1 check_out("cont_reset", 1'b0, 0, 1'b1);
        @(negedge i_clk);
        i_cont_reset = 1'b0; i_cont_stall = 1'b1;
        set_vals(1, 2, 3, 4);
        run_psum(0, "after_cont_reset");

        // Stall mid-accumulation: no acks, count and acc frozen.
        set_vals(-30, 40, 50, -7);
        @(negedge i_clk);
        i_cont_accnum = 8'd3; i_cont_shamt = 2'd1; psum_ack = 1'b0;
        sum_rdy = 1'b1; sum_zero = 1'b0; i_sum = IWd'(vals[0]);
        @(negedge i_clk);
        i_sum = IWd'(vals[1]);
        @(negedge i_clk);
        i_cont_stall = 1'b0; i_sum = 12'sd999;
        for (int i = 0; i < 3; i++) begin
            #1 expect_ack("stall_acc", 1'b0);
            @(posedge i_clk);
            #1 expect_rdy("stall_acc", 1'b0);
            @(negedge i_clk);
        end
        i_cont_stall = 1'b1; i_sum = IWd'(vals[2]);
        #1 expect_ack("stall_resume", 1'b1);
        @(negedge i_clk);
        i_sum = IWd'(vals[3]);
        @(posedge i_clk);
        #1 check_out("stall_result", 1'b1, model_psum(1), 1'b0);

        // Stall while holding the result: the ack is ignored.
        @(negedge i_clk);
        i_cont_stall = 1'b0; psum_ack = 1'b1; i_sum = 12'sd5;
        for (int i = 0; i < 3; i++) begin
            #1 expect_ack("stall_out", 1'b0);
            @(posedge i_clk);
            #1 check_out("stall_out", 1'b1, model_psum(1), 1'b0);
            @(negedge i_clk);
        end
        sum_rdy = 1'b0; i_cont_stall = 1'b1;
        @(posedge i_clk);
        #1 expect_rdy("stall_out_release", 1'b0);

        // Async reset while a result is held and again mid-psum.
        set_vals(300, 21, 0, 0);
        vals = '{300, 21}; zs = '{0, 0};
        @(negedge i_clk);
        i_cont_accnum = 8'd1; i_cont_shamt = 2'd0; psum_ack = 1'b0;
        sum_rdy = 1'b1; i_sum = 12'sd300;
        @(negedge i_clk);
        i_sum = 12'sd21;
        @(negedge i_clk);
        sum_rdy = 1'b0;
        #1 check_out("pre_rstn", 1'b1, 321, 1'b0);
        i_rstn = 1'b0;
        #1 check_out("rstn_async", 1'b0, 0, 1'b1);
        @(negedge i_clk);
        i_rstn = 1'b1; i_cont_accnum = 8'd2; sum_rdy = 1'b1; i_sum = 12'sd77;
        @(negedge i_clk);
        sum_rdy = 1'b0; i_rstn = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        vals = '{8, -3, 6}; zs = '{0, 0, 0};
        run_psum(2, "after_rstn");
    endtask

    task automatic test_random();
        int n;
        int shamt;
        for (int k = 0; k < 30; k++) begin
            n = int'($urandom_range(1, 6));
            shamt = int'($urandom_range(0, 3));
            vals.delete(); zs.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    vals.push_back(0); zs.push_back(1'b1);
                end else begin
                    vals.push_back(int'($urandom_range(0, 4095)) - 2048); zs.push_back(1'b0);
                end
            end
            run_psum(shamt, "random");
        end
    endtask

    initial begin
        test_reset();
        test_plain_acc();
        test_bitplane();
        test_saturation();
        test_backpressure();
        test_zero_flag();
        test_disruptions();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
